// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the falling-edge latch pipeline.
//   DEPTH_MAX  : deepest pipeline the design is built for.
//   occ_width  : bits needed to count 0..depth valid stages.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int DEPTH_MAX = 8;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_fall.sv
// -----------------------------------------------------------------------------
// pipe_stage_fall
// One pipeline stage: a WIDTH-bit data register plus its valid bit, updated on
// the falling edge of clk and cleared asynchronously by clr.
// Ports:
//   clk      : clock, state changes on its falling edge
//   clr      : asynchronous active-high clear (valid=0, data=RESET_VAL)
//   i_load   : stage is ready this edge; take the upstream slot
//   i_flush  : invalidate the stage; dominates i_load, data holds
//   i_valid  : upstream valid bit
//   i_data   : upstream payload
//   o_valid  : stage valid bit
//   o_data   : stage payload
// -----------------------------------------------------------------------------
module pipe_stage_fall #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  // Payload only moves when a real item moves in; a bubble passing through
  // leaves the old payload in place.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_data <= RESET_VAL;
    end else if (i_load && i_valid && !i_flush) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_latch_fall.sv
// -----------------------------------------------------------------------------
// pipe_latch_fall
// DEPTH-stage valid/ready pipeline clocked on the falling edge. Empty stages
// accept even while the output is stalled, so bubbles collapse toward the
// output end.
// Ports:
//   clk       : clock, state changes on its falling edge
//   clr       : asynchronous active-high clear of all stages
//   en        : downstream accept; the last stage empties on an edge with en=1
//   flush     : synchronous invalidate of all stages, drops the offered input
//   in_valid  : upstream offers in_data
//   in_data   : upstream payload
//   in_ready  : stage 0 can load this edge (combinational)
//   out_valid : valid bit of the last stage
//   out_data  : payload of the last stage
//   occupancy : number of valid stages (combinational)
// -----------------------------------------------------------------------------
module pipe_latch_fall
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_data    [DEPTH];
  logic [WIDTH-1:0] w_up_data [DEPTH];

  // Ready ripples from the output end back to the input: a stage is ready if
  // it is empty or the stage after it is ready (en for the last stage).
  always_comb begin
    logic w_adv;
    w_ready = '0;
    w_adv   = en;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_ready[k] = ~w_valid[k] | w_adv;
      w_adv      = w_ready[k];
    end
  end

  always_comb begin
    logic [OCC_W-1:0] w_cnt;
    w_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_cnt = w_cnt + OCC_W'(w_valid[k]);
    end
    occupancy = w_cnt;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_up_valid[k] = in_valid;
      assign w_up_data[k]  = in_data;
    end else begin : g_body
      assign w_up_valid[k] = w_valid[k-1];
      assign w_up_data[k]  = w_data[k-1];
    end

    pipe_stage_fall #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .clr     (clr),
      .i_load  (w_ready[k]),
      .i_flush (flush),
      .i_valid (w_up_valid[k]),
      .i_data  (w_up_data[k]),
      .o_valid (w_valid[k]),
      .o_data  (w_data[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];

endmodule
